treeprg_punct: RTL and testbench
================================

Name: treeprg_punct

Overview:
- Parametrised successor to the signer's tree PRG. Expands a root seed into a full binary seed tree of depth D_HYPERCUBE using the shared salted hash core.
- Adds per-node domain-separation tweaks and a punctured mode, so the verifier can rebuild every leaf except a hidden one from a preloaded sibling path.
- Sits between the sign/verify controller (seed load, leaf readout) and the shared hash engine (same start/valid/ready/force-done protocol as existing blocks).

Parameters:
- PARAMETER_SET, "L1", selects LAMBDA.
- LAMBDA, 128/192/256 for L1/L3/L5, seed size in bits.
- D_HYPERCUBE, 8, tree depth; leaves = 2^D.
- SEED_W, LAMBDA/32, words per seed.
- SALT_W, 2*LAMBDA/32, salt words.
- NODES, 2^(D+1)-1, total nodes.
- MEM_DEPTH, NODES*SEED_W, tree memory depth in words.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_start  in  1  start expansion; sampled in IDLE only.
- i_mode  in  1  0 = full expansion, 1 = punctured; latched at start.
- i_hidden_leaf  in  D_HYPERCUBE  hidden leaf index h; latched at start.
- o_busy  out  1  high from the cycle after start until DONE.
- o_done  out  1  one-cycle completion pulse.
- i_salt  in  32  salt word, one cycle after o_salt_addr.
- o_salt_addr  out  clog2(SALT_W)  salt read address.
- o_salt_rd  out  1  salt read strobe.
- i_wr_en  in  1  external seed write; root or sibling-path seeds.
- i_wr_addr  in  clog2(MEM_DEPTH)  word address, node n at n*SEED_W.
- i_wr_data  in  32  write data.
- i_rd_en  in  1  external tree read.
- i_rd_addr  in  clog2(MEM_DEPTH)  read address.
- o_rd_data  out  32  read data, 1-cycle latency.
- o_hash_data_in  out  32  hash input word.
- i_hash_addr  in  clog2(SALT_W+1+SEED_W)  hash input word index.
- i_hash_rd_en  in  1  hash input read strobe.
- i_hash_data_out  in  32  hash output word.
- i_hash_data_out_valid  in  1  output word valid.
- o_hash_data_out_ready  out  1  output word accepted.
- o_hash_input_length  out  32  constant SALT_W*32+32+LAMBDA.
- o_hash_output_length  out  32  constant 2*LAMBDA.
- o_hash_start  out  1  one-cycle hash start pulse.
- o_hash_force_done  out  1  one-cycle squeeze-terminate pulse.
- i_hash_force_done_ack  in  1  hash core acknowledges force-done.

Behaviour:
- Reset: state IDLE; node=0, level=0, word count=0; all outputs 0 (o_rd_data: memory q, don't care). Memory contents are not cleared.
- Reset mid-operation returns to IDLE within 1 cycle. o_hash_start and o_hash_force_done drop immediately. Partially written tree is undefined.
- Tree layout: node n has children 2n+1 and 2n+2; internal nodes are 0..2^D-2; leaf h is node L = 2^D-1+h.
- Hash input words:
  - Addresses 0..SALT_W-1: salt.
  - Address SALT_W: tweak = node index n, zero-extended to 32 bits.
  - Addresses SALT_W+1..SALT_W+SEED_W: parent seed words.
  - o_hash_data_in is valid 1 cycle after i_hash_rd_en/i_hash_addr. The mux select uses the registered address.
- Hash output: 2*SEED_W words. Word k < SEED_W goes to address (2n+1)*SEED_W+k; otherwise to (2n+2)*SEED_W+(k-SEED_W).
  - o_hash_data_out_ready equals i_hash_data_out_valid, combinationally, in RECV only.
  - Memory write occurs on the same cycle as the valid&ready handshake.
- States:
  - IDLE: on i_start, latch mode/h and set node=0, level=0, then go to NEXT.
  - NEXT:
    - If node > 2^D-2, go to DONE.
    - Else if mode=1 and node is on the hidden path, increment node (and level) and stay.
    - Else go to START.
    - On-path test: (L+1)>>(D-level) == node+1.
    - Level increments when node+2 == 2^(level+1).
  - START: o_hash_start=1 for one cycle, then RECV with count=0.
  - RECV: count each handshake. On the accept where count == 2*SEED_W-1, go to FDONE with o_hash_force_done=1 for one cycle.
  - FDONE: wait for i_hash_force_done_ack (may already be high on entry), then increment node and level, then NEXT.
  - DONE: o_done=1 for one cycle, then IDLE.
- Hash calls per run: full = 2^D-1; punctured = 2^D-1-D.
- Punctured mode:
  - Path nodes are never hashed or written.
  - Hidden leaf memory retains its prior contents.
  - Sibling seeds must be preloaded by the controller before start.
- Memory port priority while busy: internal hash read/write wins. i_wr_en and i_rd_en are ignored (no write).
- In IDLE: i_wr_en has priority over i_rd_en.
- i_start while busy is ignored. Simultaneous i_start and i_wr_en in IDLE: the write completes and expansion starts.
- o_salt_rd = i_hash_rd_en && hash_addr < SALT_W.

Test Plan:
- D=2, L1, mode 0, root=0x00010203..., reference hash model → 3 hash calls with tweaks 0,1,2; nodes 1..6 (words 4..27) match the software tree; o_done 1 cycle after the last ack.
- D=2, mode 1, h=1 (L=4, path 0,1,4), preload nodes 2 and 3 → exactly 1 hash call (tweak 2); words 20..27 written; words 16..19 untouched.
- D=8 L1, mode 0 → 255 hash calls, 511*4=2044 memory words; leaf 255 matches the model; o_busy high throughout.
- Valid gaps (valid toggling every other cycle) plus ack delayed 5 cycles → identical tree; no extra writes; force-done asserted exactly once per node.
- i_rst asserted in RECV of node 1 → next cycle IDLE, all outputs 0; a fresh i_start completes correctly.
- i_start and i_wr_en pulsed while busy → no restart, memory unchanged; the run finishes normally.

Source files
------------

// File: rtl/treeprg_punct.sv
// Salted seed-tree PRG: expands a root seed into a binary seed tree through the shared
// hash engine, optionally skipping the path to a hidden leaf (punctured mode).
module treeprg_punct #(
    parameter string PARAMETER_SET = "L1",
    parameter int    LAMBDA        = (PARAMETER_SET == "L5") ? 256 :
                                     (PARAMETER_SET == "L3") ? 192 : 128,
    parameter int    D_HYPERCUBE   = 8,
    localparam int   SEED_W        = LAMBDA / 32,
    localparam int   SALT_W        = 2 * LAMBDA / 32,
    localparam int   NODES         = (1 << (D_HYPERCUBE + 1)) - 1,
    localparam int   MEM_DEPTH     = NODES * SEED_W,
    localparam int   MEM_AW        = $clog2(MEM_DEPTH),
    localparam int   HASH_AW       = $clog2(SALT_W + 1 + SEED_W),
    localparam int   SALT_AW       = $clog2(SALT_W)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_mode,
    input  logic [D_HYPERCUBE-1:0] i_hidden_leaf,
    output logic                   o_busy,
    output logic                   o_done,
    input  logic [31:0]            i_salt,
    output logic [SALT_AW-1:0]     o_salt_addr,
    output logic                   o_salt_rd,
    input  logic                   i_wr_en,
    input  logic [MEM_AW-1:0]      i_wr_addr,
    input  logic [31:0]            i_wr_data,
    input  logic                   i_rd_en,
    input  logic [MEM_AW-1:0]      i_rd_addr,
    output logic [31:0]            o_rd_data,
    output logic [31:0]            o_hash_data_in,
    input  logic [HASH_AW-1:0]     i_hash_addr,
    input  logic                   i_hash_rd_en,
    input  logic [31:0]            i_hash_data_out,
    input  logic                   i_hash_data_out_valid,
    output logic                   o_hash_data_out_ready,
    output logic [31:0]            o_hash_input_length,
    output logic [31:0]            o_hash_output_length,
    output logic                   o_hash_start,
    output logic                   o_hash_force_done,
    input  logic                   i_hash_force_done_ack
);

    localparam int NODE_W        = D_HYPERCUBE + 1;
    localparam int LVL_W         = $clog2(D_HYPERCUBE + 1);
    localparam int CNT_W         = $clog2(2 * SEED_W);
    localparam int LAST_INTERNAL = (1 << D_HYPERCUBE) - 2;

    typedef enum logic [2:0] {S_IDLE, S_NEXT, S_START, S_RECV, S_FDONE, S_DONE} state_t;
    typedef enum logic [1:0] {SEL_ZERO, SEL_SALT, SEL_TWEAK, SEL_SEED} sel_t;

    state_t                 state;
    sel_t                   sel_q;
    logic [NODE_W-1:0]      node;
    logic [LVL_W-1:0]       level;
    logic [CNT_W-1:0]       count;
    logic                   mode_q;
    logic [D_HYPERCUBE-1:0] hidden_q;
    logic                   busy_q, done_q, start_q, fdone_q;
    logic [31:0]            mem [MEM_DEPTH];
    logic [31:0]            rd_q;

    int                     node_i, haddr_i;
    logic                   in_idle, on_path, level_inc, last_word, accept, in_seed;
    logic                   mem_we, mem_re;
    logic [MEM_AW-1:0]      mem_waddr, mem_raddr;
    logic [31:0]            mem_wdata;

    assign in_idle   = (state == S_IDLE);
    assign node_i    = int'(node);
    assign haddr_i   = int'(i_hash_addr);
    // Ancestor of leaf L at this level is ((L+1) >> (D-level)) - 1.
    assign on_path   = ((((1 << D_HYPERCUBE) + int'(hidden_q)) >> (D_HYPERCUBE - int'(level)))
                        == node_i + 1);
    assign level_inc = (node_i + 2 == (1 << (int'(level) + 1)));
    assign accept    = (state == S_RECV) && i_hash_data_out_valid;
    assign last_word = (int'(count) == 2 * SEED_W - 1);
    assign in_seed   = (haddr_i > SALT_W) && (haddr_i <= SALT_W + SEED_W);

    always_comb begin
        // NOTE: every signal gets a default before the branches, so no latch is inferred.
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_waddr = i_wr_addr;
        mem_wdata = i_wr_data;
        mem_raddr = i_rd_addr;
        if (in_idle) begin
            mem_we = i_wr_en;
            mem_re = i_rd_en && !i_wr_en;
        end else begin
            // Left child word k, right child word k-SEED_W: both are (2n+1)*SEED_W + k.
            mem_we    = accept;
            mem_waddr = MEM_AW'((2 * node_i + 1) * SEED_W + int'(count));
            mem_wdata = i_hash_data_out;
            mem_re    = i_hash_rd_en && in_seed;
            mem_raddr = MEM_AW'(node_i * SEED_W + haddr_i - SALT_W - 1);
        end
    end

    // NOTE: the tree memory has no reset so it maps onto block RAM; contents survive i_rst.
    always_ff @(posedge i_clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (mem_re) rd_q <= mem[mem_raddr];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            sel_q <= SEL_ZERO;
        else if (!in_idle && i_hash_rd_en)
            sel_q <= (haddr_i < SALT_W) ? SEL_SALT : (haddr_i == SALT_W) ? SEL_TWEAK : SEL_SEED;
        else
            sel_q <= SEL_ZERO;
    end

    always_comb begin
        unique case (sel_q)
            SEL_SALT:  o_hash_data_in = i_salt;
            SEL_TWEAK: o_hash_data_in = 32'(node);
            SEL_SEED:  o_hash_data_in = rd_q;
            default:   o_hash_data_in = '0;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            node     <= '0;
            level    <= '0;
            count    <= '0;
            mode_q   <= 1'b0;
            hidden_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            start_q  <= 1'b0;
            fdone_q  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (i_start) begin
                    mode_q   <= i_mode;
                    hidden_q <= i_hidden_leaf;
                    node     <= '0;
                    level    <= '0;
                    count    <= '0;
                    busy_q   <= 1'b1;
                    state    <= S_NEXT;
                end
                S_NEXT: begin
                    if (node_i > LAST_INTERNAL) begin
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end else if (mode_q && on_path) begin
                        node <= node + 1'b1;
                        if (level_inc) level <= level + 1'b1;
                    end else begin
                        start_q <= 1'b1;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    start_q <= 1'b0;
                    count   <= '0;
                    state   <= S_RECV;
                end
                S_RECV: if (accept) begin
                    if (last_word) begin
                        fdone_q <= 1'b1;
                        state   <= S_FDONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_FDONE: begin
                    fdone_q <= 1'b0;
                    if (i_hash_force_done_ack) begin
                        node  <= node + 1'b1;
                        if (level_inc) level <= level + 1'b1;
                        state <= S_NEXT;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_busy                = busy_q;
    assign o_done                = done_q;
    assign o_hash_start          = start_q;
    assign o_hash_force_done     = fdone_q;
    assign o_hash_data_out_ready = accept;
    assign o_rd_data             = rd_q;
    assign o_salt_rd             = !in_idle && i_hash_rd_en && (haddr_i < SALT_W);
    assign o_salt_addr           = o_salt_rd ? i_hash_addr[SALT_AW-1:0] : '0;
    assign o_hash_input_length   = 32'(SALT_W * 32 + 32 + LAMBDA);
    assign o_hash_output_length  = 32'(2 * LAMBDA);

endmodule

// File: tb/tb_treeprg_punct.sv
// Self-checking bench for treeprg_punct: behavioural hash engine, tree model and read scoreboard.
module tb_treeprg_punct;

    localparam int D         = 4;
    localparam int LAMBDA    = 128;
    localparam int S         = LAMBDA / 32;
    localparam int SALT_W    = 2 * LAMBDA / 32;
    localparam int LEAVES    = 1 << D;
    localparam int NODES     = 2 * LEAVES - 1;
    localparam int MEM_DEPTH = NODES * S;
    localparam int HIN       = SALT_W + 1 + S;
    localparam int AW        = $clog2(MEM_DEPTH);
    localparam int HAW       = $clog2(HIN);
    localparam int SAW       = $clog2(SALT_W);

    logic              i_clk = 1'b0;
    logic              i_rst, i_start, i_mode;
    logic [D-1:0]      i_hidden_leaf;
    logic              o_busy, o_done;
    logic [31:0]       i_salt;
    logic [SAW-1:0]    o_salt_addr;
    logic              o_salt_rd;
    logic              i_wr_en, i_rd_en;
    logic [AW-1:0]     i_wr_addr, i_rd_addr;
    logic [31:0]       i_wr_data, o_rd_data, o_hash_data_in;
    logic [HAW-1:0]    i_hash_addr;
    logic              i_hash_rd_en;
    logic [31:0]       i_hash_data_out;
    logic              i_hash_data_out_valid, o_hash_data_out_ready;
    logic [31:0]       o_hash_input_length, o_hash_output_length;
    logic              o_hash_start, o_hash_force_done, i_hash_force_done_ack;

    treeprg_punct #(.PARAMETER_SET("L1"), .D_HYPERCUBE(D)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode),
        .i_hidden_leaf(i_hidden_leaf), .o_busy(o_busy), .o_done(o_done),
        .i_salt(i_salt), .o_salt_addr(o_salt_addr), .o_salt_rd(o_salt_rd),
        .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
        .o_hash_data_in(o_hash_data_in), .i_hash_addr(i_hash_addr),
        .i_hash_rd_en(i_hash_rd_en), .i_hash_data_out(i_hash_data_out),
        .i_hash_data_out_valid(i_hash_data_out_valid),
        .o_hash_data_out_ready(o_hash_data_out_ready),
        .o_hash_input_length(o_hash_input_length),
        .o_hash_output_length(o_hash_output_length),
        .o_hash_start(o_hash_start), .o_hash_force_done(o_hash_force_done),
        .i_hash_force_done_ack(i_hash_force_done_ack)
    );

    always #5 i_clk = ~i_clk;

    int          checks = 0, errors = 0;
    logic [31:0] salt_m [SALT_W];
    logic [31:0] mem_m  [MEM_DEPTH];
    logic [31:0] full_m [MEM_DEPTH];
    logic [31:0] exp_rd[$];
    int          exp_tweak[$];
    int          calls = 0, fd_cnt = 0, eng_outk = 0;
    bit          eng_busy = 0, abort_req = 0, gap_rand = 0;
    int          gap_max = 0, ack_max = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Stand-in for the salted hash: any fixed mixing of all input words will do.
    function automatic logic [31:0] href(input logic [HIN-1:0][31:0] w, input int k);
        logic [31:0] acc;
        acc = 32'h811c9dc5 ^ 32'(k);
        for (int i = 0; i < HIN; i++) begin
            acc = (acc ^ w[i]) * 32'h01000193;
            acc = {acc[18:0], acc[31:19]} + 32'(i);
        end
        return acc ^ (acc >> 15);
    endfunction

    function automatic bit on_path(input int n, input int h);
        int x;
        x = LEAVES - 1 + h;
        forever begin
            if (x == n) return 1'b1;
            if (x == 0) return 1'b0;
            x = (x - 1) / 2;
        end
    endfunction

    task automatic gen_children(input int n, input bit to_full);
        logic [HIN-1:0][31:0] w;
        int idx;
        for (int i = 0; i < SALT_W; i++) w[i] = salt_m[i];
        w[SALT_W] = 32'(n);
        for (int j = 0; j < S; j++) w[SALT_W + 1 + j] = to_full ? full_m[n * S + j] : mem_m[n * S + j];
        for (int k = 0; k < 2 * S; k++) begin
            idx = (k < S) ? (2 * n + 1) * S + k : (2 * n + 2) * S + k - S;
            if (to_full) full_m[idx] = href(w, k);
            else         mem_m[idx]  = href(w, k);
        end
    endtask

    // Salt RAM: data for the address presented this cycle appears after the next edge.
    initial begin : salt_ram
        bit             s_rd;
        logic [SAW-1:0] s_a;
        i_salt = '0;
        forever begin
            @(posedge i_clk);
            s_rd = o_salt_rd;
            s_a  = o_salt_addr;
            #1;
            if (s_rd) i_salt = salt_m[s_a];
        end
    end

    // Hash engine model: read input words, squeeze 2*S words, honour force-done.
    initial begin : engine
        logic [HIN-1:0][31:0] win;
        logic [31:0]          outw [2 * S];
        bit                   ab, seen;
        int                   t;
        i_hash_rd_en = 0; i_hash_addr = '0; i_hash_data_out = '0;
        i_hash_data_out_valid = 0; i_hash_force_done_ack = 0;
        forever begin
            @(negedge i_clk);
            if (o_hash_start && !abort_req) begin
                eng_busy = 1; ab = 0; eng_outk = 0; calls++;
                for (int a = 0; a <= HIN && !ab; a++) begin
                    if (a > 0) win[a - 1] = o_hash_data_in;
                    if (a < HIN) begin i_hash_addr = HAW'(a); i_hash_rd_en = 1; end
                    else i_hash_rd_en = 0;
                    @(negedge i_clk);
                    ab = abort_req;
                end
                i_hash_rd_en = 0;
                if (!ab) begin
                    if (exp_tweak.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL tweak_unexpected actual=%0d expected=none", win[SALT_W]);
                    end else begin
                        check("tweak", win[SALT_W], 32'(exp_tweak.pop_front()));
                    end
                    for (int k = 0; k < 2 * S; k++) outw[k] = href(win, k);
                    for (int k = 0; k < 2 * S && !ab; k++) begin
                        t = gap_rand ? $urandom_range(0, gap_max) : gap_max;
                        for (int g = 0; g < t && !ab; g++) begin @(negedge i_clk); ab = abort_req; end
                        if (!ab) begin
                            i_hash_data_out_valid = 1;
                            i_hash_data_out       = outw[k];
                            @(negedge i_clk);
                            i_hash_data_out_valid = 0;
                            eng_outk = k + 1;
                            ab = abort_req;
                        end
                    end
                end
                if (!ab) begin
                    seen = 0;
                    for (int c = 0; c < 20 && !seen && !abort_req; c++) begin
                        if (o_hash_force_done) seen = 1;
                        else @(negedge i_clk);
                    end
                    check("force_done_seen", 32'(seen), 32'd1);
                    if (seen) begin
                        t = gap_rand ? $urandom_range(0, ack_max) : ack_max;
                        repeat (t) @(negedge i_clk);
                        i_hash_force_done_ack = 1;
                        @(negedge i_clk);
                        i_hash_force_done_ack = 0;
                    end
                end
                i_hash_data_out_valid = 0; i_hash_force_done_ack = 0;
                eng_busy = 0;
            end
        end
    end

    initial begin : fd_counter
        forever begin
            @(negedge i_clk);
            if (o_hash_force_done) fd_cnt++;
        end
    end

    // Read scoreboard: a read accepted at an edge is compared at the following negedge.
    initial begin : rd_monitor
        bit take;
        forever begin
            @(posedge i_clk);
            take = i_rd_en && !i_wr_en && !o_busy && !i_rst;
            @(negedge i_clk);
            if (take) begin
                if (exp_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected actual=%h expected=none", o_rd_data);
                end else begin
                    check("rd_data", o_rd_data, exp_rd.pop_front());
                end
            end
        end
    end

    task automatic wr(input int a, input logic [31:0] d);
        i_wr_en = 1; i_wr_addr = AW'(a); i_wr_data = d; mem_m[a] = d;
        @(negedge i_clk);
        i_wr_en = 0;
    endtask

    task automatic readback();
        for (int a = 0; a < MEM_DEPTH; a++) begin
            i_rd_en = 1; i_rd_addr = AW'(a); exp_rd.push_back(mem_m[a]);
            @(negedge i_clk);
        end
        i_rd_en = 0;
        repeat (2) @(negedge i_clk);
        check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    endtask

    task automatic recover();
        abort_req = 1; i_rst = 1;
        @(negedge i_clk);
        i_rst = 0;
        for (int c = 0; c < 100 && eng_busy; c++) @(negedge i_clk);
        abort_req = 0;
        exp_tweak.delete();
    endtask

    task automatic new_keys();
        for (int i = 0; i < SALT_W; i++) salt_m[i] = $urandom;
        for (int j = 0; j < S; j++) full_m[j] = $urandom;
        for (int n = 0; n <= LEAVES - 2; n++) gen_children(n, 1'b1);
    endtask

    task automatic run_tree(input bit mode, input int h, input int gap, input bit grand,
                            input int ack, input bit poke);
        int  x, sib, exp_calls;
        bit  busy_low, got_done;
        new_keys();
        gap_max = gap; gap_rand = grand; ack_max = ack;
        if (mode) begin
            for (int j = 0; j < S; j++) wr((LEAVES - 1 + h) * S + j, 32'hDEAD0000 | 32'(j));
            x = LEAVES - 1 + h;
            while (x != 0) begin
                sib = (x % 2 == 1) ? x + 1 : x - 1;
                for (int j = 0; j < S; j++) wr(sib * S + j, full_m[sib * S + j]);
                x = (x - 1) / 2;
            end
        end
        for (int j = 0; j < S - 1; j++) wr(j, full_m[j]);
        mem_m[S - 1] = full_m[S - 1];
        for (int n = 0; n <= LEAVES - 2; n++) begin
            if (!(mode && on_path(n, h))) begin
                exp_tweak.push_back(n);
                gen_children(n, 1'b0);
            end
        end
        exp_calls = mode ? LEAVES - 1 - D : LEAVES - 1;
        calls = 0; fd_cnt = 0;
        // Last root word is written in the same cycle as the start request.
        i_wr_en = 1; i_wr_addr = AW'(S - 1); i_wr_data = full_m[S - 1];
        i_start = 1; i_mode = mode; i_hidden_leaf = D'(h);
        @(negedge i_clk);
        i_wr_en = 0; i_start = 0;
        busy_low = 0; got_done = 0;
        for (int cyc = 0; cyc < 6000 && !got_done; cyc++) begin
            if (o_done) got_done = 1;
            else begin
                if (!o_busy) busy_low = 1;
                if (poke && cyc == 40) begin
                    i_start = 1; i_wr_en = 1; i_wr_addr = '0; i_wr_data = 32'hBAD0BAD0;
                    i_rd_en = 1; i_rd_addr = '0; i_mode = ~mode;
                end else begin
                    i_start = 0; i_wr_en = 0; i_rd_en = 0;
                end
                @(negedge i_clk);
            end
        end
        i_start = 0; i_wr_en = 0; i_rd_en = 0;
        check("done_seen", 32'(got_done), 32'd1);
        check("busy_during_run", 32'(busy_low), 32'd0);
        @(negedge i_clk);
        check("done_one_cycle", 32'(o_done), 32'd0);
        check("busy_after_done", 32'(o_busy), 32'd0);
        check("hash_calls", 32'(calls), 32'(exp_calls));
        check("force_done_count", 32'(fd_cnt), 32'(exp_calls));
        check("tweaks_consumed", 32'(exp_tweak.size()), 32'd0);
        if (!got_done) recover();
        readback();
    endtask

    task automatic reset_mid_run();
        bit trig;
        new_keys();
        gap_max = 0; gap_rand = 0; ack_max = 0;
        for (int j = 0; j < S; j++) wr(j, full_m[j]);
        for (int n = 0; n <= LEAVES - 2; n++) exp_tweak.push_back(n);
        calls = 0;
        i_start = 1; i_mode = 0; i_hidden_leaf = '0;
        @(negedge i_clk);
        i_start = 0;
        trig = 0;
        for (int c = 0; c < 3000 && !trig; c++) begin
            if (calls >= 2 && eng_outk >= 1) trig = 1;
            else @(negedge i_clk);
        end
        check("reset_trigger_reached", 32'(trig), 32'd1);
        abort_req = 1; i_rst = 1;
        @(negedge i_clk);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_hash_start", 32'(o_hash_start), 32'd0);
        check("rst_force_done", 32'(o_hash_force_done), 32'd0);
        check("rst_ready", 32'(o_hash_data_out_ready), 32'd0);
        check("rst_salt_rd", 32'(o_salt_rd), 32'd0);
        check("rst_hash_data_in", o_hash_data_in, 32'd0);
        i_rst = 0;
        for (int c = 0; c < 100 && eng_busy; c++) @(negedge i_clk);
        abort_req = 0;
        exp_tweak.delete();
        @(negedge i_clk);
        check("rst_stays_idle", 32'(o_busy), 32'd0);
    endtask

    initial begin : main
        i_rst = 1; i_start = 0; i_mode = 0; i_hidden_leaf = '0;
        i_wr_en = 0; i_wr_addr = '0; i_wr_data = '0; i_rd_en = 0; i_rd_addr = '0;
        repeat (3) @(negedge i_clk);
        i_rst = 0;
        check("init_busy", 32'(o_busy), 32'd0);
        check("init_done", 32'(o_done), 32'd0);
        check("init_hash_start", 32'(o_hash_start), 32'd0);
        check("init_force_done", 32'(o_hash_force_done), 32'd0);
        check("init_salt_rd", 32'(o_salt_rd), 32'd0);
        check("init_salt_addr", 32'(o_salt_addr), 32'd0);
        check("init_hash_data_in", o_hash_data_in, 32'd0);
        check("input_length", o_hash_input_length, 32'(SALT_W * 32 + 32 + LAMBDA));
        check("output_length", o_hash_output_length, 32'(2 * LAMBDA));

        for (int a = 0; a < MEM_DEPTH; a++) wr(a, $urandom);

        run_tree(1'b0, 0, 0, 1'b0, 0, 1'b0);
        run_tree(1'b1, 1, 0, 1'b0, 0, 1'b0);
        run_tree(1'b1, 0, 0, 1'b0, 1, 1'b0);
        run_tree(1'b1, LEAVES - 1, 1, 1'b0, 5, 1'b0);
        run_tree(1'b0, 3, 1, 1'b0, 5, 1'b1);
        reset_mid_run();
        run_tree(1'b0, 0, 2, 1'b1, 3, 1'b0);
        for (int r = 0; r < 3; r++)
            run_tree(1'($urandom_range(0, 1)), $urandom_range(0, LEAVES - 1),
                     $urandom_range(0, 2), 1'b1, $urandom_range(0, 4), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
